prog_loader: RTL and testbench

- Parametrised instruction-memory loader for the single-cycle cpu. Replaces hand-sequenced initialize/address/data driving.
- Accepts a valid/ready stream of instruction words and writes them word-by-word into imem from BASE_ADDR with stride 4.
- Optionally pads the rest of imem with NOPs.
- Holds the cpu in reset until loading completes, then releases it after a programmable hold.

---
 rtl/prog_loader_pkg.sv | 6 +
 rtl/prog_loader_if.sv | 8 +
 rtl/prog_loader.sv | 100 ++++++++++
 tb/tb_prog_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and constants for the imem loader.
package prog_loader_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PAD, RELEASE, RUN, ERROR} state_t;
  localparam int WORD_STRIDE = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: valid/ready instruction-word stream into the loader.
interface prog_loader_if #(parameter int DATA_W = 32);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  modport master(output in_valid, output in_data, input in_ready);
  modport slave(input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams words into imem, optionally NOP-pads, then releases cpu reset.
// Optional PROG_LOADER_CHECKSUM_EN gates the release on a running sum of loaded words.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int PAD_NOP = 1,
  parameter int RST_HOLD = 4,
  localparam int IW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [IW-1:0] word_count,
`ifdef PROG_LOADER_CHECKSUM_EN
  input  logic [DATA_W-1:0] expected_sum,
`endif
  prog_loader_if.slave s,
  output logic initialize,
  output logic imem_we,
  output logic [31:0] instruction_initialize_address,
  output logic [DATA_W-1:0] instruction_initialize_data,
  output logic cpu_rst,
  output logic busy,
  output logic done,
  output logic error
);
  localparam logic [31:0] BASE = BASE_ADDR & ~32'd3;
  localparam int HW = $clog2(RST_HOLD + 1);
  state_t state, nxt;
  logic [IW-1:0] cnt, idx;
  logic [HW-1:0] hold;
  logic go, bad, accept, pad_go, sum_ok;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum, exp_sum;
  assign sum_ok = sum == exp_sum;
`else
  assign sum_ok = 1'b1;
`endif
  assign bad = word_count == '0 || word_count > IW'(DEPTH);
  assign go = start && (state == IDLE || state == RUN);
  assign s.in_ready = state == LOAD && idx < cnt;
  assign accept = s.in_valid && s.in_ready;
  assign pad_go = state == PAD && idx < IW'(DEPTH);
  assign initialize = state == LOAD || state == PAD;
  assign cpu_rst = state != RUN;
  assign busy = state == LOAD || state == PAD || state == RELEASE;
  assign done = state == RUN;
  assign error = state == ERROR;
  // idx == limit marks the cycle the final write of a phase is on the imem port
  always_comb begin
    nxt = state;
    case (state)
      IDLE, RUN: if (start) nxt = bad ? ERROR : LOAD;
      LOAD: if (idx == cnt) nxt = !sum_ok ? ERROR : (PAD_NOP != 0 && cnt < IW'(DEPTH)) ? PAD : RELEASE;
      PAD: if (idx == IW'(DEPTH)) nxt = RELEASE;
      RELEASE: if (hold == HW'(RST_HOLD - 1)) nxt = RUN;
      default: ;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      hold <= '0;
      imem_we <= 1'b0;
      instruction_initialize_address <= BASE;
      instruction_initialize_data <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum <= '0;
      exp_sum <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      hold <= state == RELEASE ? hold + HW'(1) : '0;
      if (go && !bad) begin
        cnt <= word_count;
        idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum <= '0;
        exp_sum <= expected_sum;
`endif
      end
      if (accept || pad_go) begin
        imem_we <= 1'b1;
        instruction_initialize_address <= BASE + 32'(WORD_STRIDE) * 32'(idx);
        instruction_initialize_data <= accept ? s.in_data : DATA_W'(NOP_WORD);
        idx <= idx + IW'(1);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (accept) sum <= sum + s.in_data;
`endif
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed loads checked against a queue of expected imem writes.
module tb_prog_loader;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int IW = $clog2(DEPTH + 1);
  localparam int HOLD = 4;
  localparam logic [31:0] BASE = 32'h0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [IW-1:0] word_count = '0;
  logic initialize, imem_we, cpu_rst, busy, done, error;
  logic [31:0] addr;
  logic [DW-1:0] data;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DW-1:0] expected_sum = '0;
`endif
  prog_loader_if #(.DATA_W(DW)) s();
  prog_loader #(.DATA_W(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .PAD_NOP(1), .RST_HOLD(HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .word_count(word_count),
`ifdef PROG_LOADER_CHECKSUM_EN
    .expected_sum(expected_sum),
`endif
    .s(s),
    .initialize(initialize),
    .imem_we(imem_we),
    .instruction_initialize_address(addr),
    .instruction_initialize_data(data),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .error(error)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, last_wr = 0;
  int wr_cyc[$];
  logic [31:0] exp_a[$], exp_d[$], words[$];
  logic [31:0] mem[DEPTH];
  function void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endfunction
  // expected imem traffic: loaded words in order, then NOPs to the end when padding applies
  function automatic void plan(int n, bit pad);
    for (int i = 0; i < DEPTH; i++)
      if (i < n || pad) begin
        exp_a.push_back(BASE + 32'(4 * i));
        exp_d.push_back(i < n ? words[i] : 32'h0);
      end
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    chk("done_vs_cpu_rst", done, !cpu_rst);
    chk("error_keeps_rst", error && !cpu_rst, 0);
    if (imem_we) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_write got addr %h data %h want no write", addr, data);
      end else begin
        chk("wr_addr", addr, exp_a.pop_front());
        chk("wr_data", data, exp_d.pop_front());
        chk("wr_init", initialize, 1);
      end
      mem[addr[4:2]] = data;
      wr_cyc.push_back(cyc);
      last_wr = cyc;
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    s.in_valid = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask
  task automatic kick(int n);
    word_count = IW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic feed(int n, logic [31:0] pat);
    int k = 0, t = 0;
    bit acc;
    while (k < n && t < 32) begin
      s.in_valid = pat[t];
      s.in_data = words[k];
      acc = s.in_valid && s.in_ready;
      tick();
      if (acc) k++;
      t++;
    end
    s.in_valid = 1'b0;
    chk("feed_accepted", k, n);
  endtask
  task automatic wait_done(string name);
    int t = 0;
    while (!done && t < 64) begin
      tick();
      t++;
    end
    chk(name, done, 1);
  endtask
`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic cs_run(logic [31:0] want_sum);
    bit ok;
    words = '{32'h1, 32'hFFFF_FFFF};
    expected_sum = want_sum;
    ok = (words[0] + words[1]) == want_sum;
    plan(2, ok);
    kick(2);
    feed(2, 32'hFFFF_FFFF);
    if (ok) wait_done("cs_done");
    else begin
      tick(4);
      chk("cs_err_state", {error, cpu_rst, done, busy}, 4'b1100);
    end
    chk("cs_writes_left", exp_a.size(), 0);
  endtask
`endif
  initial begin
    s.in_valid = 1'b0;
    s.in_data = '0;
    tick(3);
    chk("rst_flags", {cpu_rst, initialize, s.in_ready, done, error, busy, imem_we}, 7'b1000000);
    chk("rst_addr", addr, BASE);
    chk("rst_data", data, 0);
    rst = 1'b0;
    tick();
    words = '{32'h0041_1020, 32'h0084_4022, 32'h00A6_3825};
    wr_cyc.delete();
    plan(3, 1);
    kick(3);
    feed(3, 32'hFFFF_FFFF);
    chk("t1_ready_drop", s.in_ready, 0);
    wait_done("t1_done");
    chk("t1_consecutive", wr_cyc[2] - wr_cyc[0], 2);
    chk("t1_write_count", wr_cyc.size(), 8);
    chk("t1_hold", cyc - last_wr - 1, HOLD);
    chk("t1_left", exp_a.size(), 0);
    chk("t1_mem0", mem[0], 32'h0041_1020);
    chk("t1_mem2", mem[2], 32'h00A6_3825);
    chk("t1_mem7", mem[7], 32'h0);
    words = '{32'h1111_1111, 32'h2222_2222};
    wr_cyc.delete();
    plan(2, 1);
    kick(2);
    chk("t2_rst_after_start", {cpu_rst, done, busy}, 3'b101);
    feed(2, 32'b1001);
    wait_done("t2_done");
    chk("t2_gap", wr_cyc[1] - wr_cyc[0], 3);
    chk("t2_write_count", wr_cyc.size(), 8);
    chk("t2_mem1", mem[1], 32'h2222_2222);
    chk("t2_left", exp_a.size(), 0);
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back(32'h1000_0000 + 32'(i));
    wr_cyc.delete();
    plan(8, 1);
    kick(8);
    feed(8, 32'hFFFF_FFFF);
    chk("t3_last_addr", addr, 32'd28);
    tick();
    chk("t3_release", {busy, initialize, imem_we, cpu_rst}, 4'b1001);
    wait_done("t3_done");
    chk("t3_write_count", wr_cyc.size(), 8);
    chk("t3_hold", cyc - last_wr - 1, HOLD);
    chk("t3_left", exp_a.size(), 0);
    words = '{32'hA, 32'hB, 32'hC, 32'hD};
    plan(2, 0);
    kick(4);
    feed(2, 32'hFFFF_FFFF);
    rst = 1'b1;
    tick();
    chk("t4_rst_flags", {initialize, imem_we, s.in_ready, busy, cpu_rst}, 5'b00001);
    chk("t4_rst_addr", addr, BASE);
    tick(2);
    rst = 1'b0;
    chk("t4_left", exp_a.size(), 0);
    tick();
    kick(0);
    chk("t5_zero", {error, cpu_rst, busy, done}, 4'b1100);
    kick(4);
    chk("t5_sticky", {error, busy}, 2'b10);
    do_reset();
    chk("t5_cleared", error, 0);
    kick(9);
    chk("t5_over", {error, cpu_rst}, 2'b11);
    do_reset();
`ifdef PROG_LOADER_CHECKSUM_EN
    cs_run(32'h0);
    cs_run(32'h5);
`endif
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
